// File: rtl/univ_shift_register.sv
// Universal N-bit shift register: hold, shift, rotate, load and clear,
// applied once immediately or repeated by a counted-step sequencer.
module univ_shift_register #(
    parameter  int N  = 8,
    localparam int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          si_r,
    input  logic          si_l,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          so_r,
    output logic          so_l,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_ROR  = 3'b011,
        M_ROL  = 3'b100,
        M_LOAD = 3'b101,
        M_CLR  = 3'b110,
        M_RSVD = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    mode_e         mode_q,  mode_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          req_cnt;
    logic [AW-1:0] amt_c;
    mode_e         mode_in;

    function automatic logic [N-1:0] step_f(
        input mode_e        m,
        input logic [N-1:0] v,
        input logic         sr,
        input logic         sl,
        input logic [N-1:0] ld
    );
        logic [N-1:0] r;
        r = v;
        case (m)
            M_SHR:   r = {sr, v[N-1:1]};
            M_SHL:   r = {v[N-2:0], sl};
            M_ROR:   r = {v[0], v[N-1:1]};
            M_ROL:   r = {v[N-2:0], v[N-1]};
            M_LOAD:  r = ld;
            M_CLR:   r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    assign mode_in = mode_e'(mode);

    // Only the four shift/rotate modes may be repeated by the sequencer.
    assign req_cnt = start &&
                     (mode_in == M_SHR || mode_in == M_SHL ||
                      mode_in == M_ROR || mode_in == M_ROL);

    assign amt_c = (amt > AW'(N)) ? AW'(N) : amt;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_cnt && amt_c != '0) begin
                    state_d = RUN;
                    mode_d  = mode_in;
                    cnt_d   = amt_c;
                    busy_d  = 1'b1;
                end else if (req_cnt) begin
                    done_d = 1'b1;
                end else if (en) begin
                    data_d = step_f(mode_in, data_q, si_r, si_l, d);
                end
            end
            RUN: begin
                data_d = step_f(mode_q, data_q, si_r, si_l, d);
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = data_q;
    assign so_r = data_q[0];
    assign so_l = data_q[N-1];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Scoreboard bench for univ_shift_register: a behavioural model queues
// the expected state per edge, compared one edge later.
module tb_univ_shift_register;

    localparam int N  = 8;
    localparam int AW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst, en, start, si_r, si_l;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  d, q;
    logic          so_r, so_l, busy, done;

    univ_shift_register #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .amt(amt), .si_r(si_r), .si_l(si_l), .d(d), .q(q),
        .so_r(so_r), .so_l(so_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [N-1:0] m_q = '0;
    logic         m_run = 1'b0;
    logic         m_done = 1'b0;
    logic [2:0]   m_mode = 3'b000;
    int           m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] mstep(input logic [2:0] m,
        input logic [N-1:0] v, input logic sr, input logic sl,
        input logic [N-1:0] ld);
        logic [N-1:0] msb;
        msb = {1'b1, {(N-1){1'b0}}};
        case (m)
            3'd1: return (v >> 1) | (sr ? msb : '0);
            3'd2: return (v << 1) | N'(sl);
            3'd3: return (v >> 1) | (v[0] ? msb : '0);
            3'd4: return (v << 1) | N'(v[N-1]);
            3'd5: return ld;
            3'd6: return '0;
            default: return v;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic s, input int a, input logic sr,
                       input logic sl, input logic [N-1:0] dd);
        exp_t ex;
        int   ac;
        rst = r; en = e; mode = m; start = s; amt = AW'(a);
        si_r = sr; si_l = sl; d = dd;
        if (!r) begin
            check("so_r", 32'(so_r), 32'(m_q[0]));
            check("so_l", 32'(so_l), 32'(m_q[N-1]));
        end
        ac = (a > N) ? N : a;
        if (r) begin
            m_q = '0; m_run = 0; m_done = 0; m_cnt = 0;
        end else if (m_run) begin
            m_q = mstep(m_mode, m_q, sr, sl, dd);
            m_cnt = m_cnt - 1;
            m_done = (m_cnt == 0);
            if (m_cnt == 0) m_run = 0;
        end else begin
            m_done = 0;
            if (s && m >= 3'd1 && m <= 3'd4) begin
                if (ac == 0) m_done = 1;
                else begin
                    m_run = 1; m_mode = m; m_cnt = ac;
                end
            end else if (e) begin
                m_q = mstep(m, m_q, sr, sl, dd);
            end
        end
        ex.q = m_q; ex.busy = m_run; ex.done = m_done;
        sb.push_back(ex);
        @(posedge clk); #1;
        ex = sb.pop_front();
        check("q", 32'(q), 32'(ex.q));
        check("busy", 32'(busy), 32'(ex.busy));
        check("done", 32'(done), 32'(ex.done));
    endtask

    task automatic op(input logic [2:0] m, input logic sr, input logic sl,
                      input logic [N-1:0] dd);
        cyc(0, 1, m, 0, 0, sr, sl, dd);
    endtask

    task automatic idle(input logic sr, input logic sl);
        cyc(0, 0, 3'd0, 0, 0, sr, sl, '0);
    endtask

    task automatic go(input logic [2:0] m, input int a, input logic sr,
                      input logic sl);
        cyc(0, 1, m, 1, a, sr, sl, '0);
    endtask

    int           bcnt;
    logic [N-1:0] ser;
    logic [N-1:0] ser_exp;

    initial begin
        rst = 1; en = 0; mode = 0; start = 0; amt = '0;
        si_r = 0; si_l = 0; d = '0;
        cyc(1, 0, 3'd0, 0, 0, 0, 0, '0);
        cyc(1, 0, 3'd0, 0, 0, 0, 0, '0);

        op(3'd5, 0, 0, 8'hA5);
        check("load_a5", 32'(q), 32'h A5);
        cyc(1, 1, 3'd5, 0, 0, 0, 0, 8'hFF);
        check("rst_q", 32'(q), 32'h0);
        op(3'd5, 0, 0, 8'h33);
        cyc(1, 1, 3'd1, 1, 4, 0, 0, '0);
        idle(0, 0);
        check("rst_start_busy", 32'(busy), 32'h0);
        check("rst_start_q", 32'(q), 32'h0);

        op(3'd5, 0, 0, 8'h81);
        op(3'd3, 0, 0, '0); check("ror", 32'(q), 32'hC0);
        op(3'd4, 0, 0, '0); check("rol", 32'(q), 32'h81);
        op(3'd2, 0, 1, '0); check("shl", 32'(q), 32'h03);
        op(3'd1, 0, 0, '0); check("shr", 32'(q), 32'h01);
        op(3'd6, 0, 0, '0); check("clr", 32'(q), 32'h00);
        op(3'd5, 0, 0, 8'h6B);
        op(3'd7, 1, 1, 8'hFF); check("rsvd", 32'(q), 32'h6B);
        cyc(0, 1, 3'd5, 1, 3, 0, 0, 8'h42);
        check("bad_start_load", 32'(q), 32'h42);

        op(3'd5, 0, 0, 8'hF0);
        go(3'd1, 4, 0, 0);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 3'($urandom_range(0, 7)), i[0], 2, 0, 0, 8'hFF);
            if (busy) bcnt++;
        end
        check("cnt4_q", 32'(q), 32'h0F);
        check("cnt4_done", 32'(done), 32'h1);
        check("cnt4_busy_cycles", 32'(bcnt), 32'd4);
        idle(0, 0);
        check("cnt4_done_pulse", 32'(done), 32'h0);

        op(3'd5, 0, 0, 8'h3C);
        go(3'd2, 0, 1, 1);
        check("amt0_done", 32'(done), 32'h1);
        check("amt0_busy", 32'(busy), 32'h0);
        check("amt0_q", 32'(q), 32'h3C);
        idle(0, 0);

        op(3'd5, 0, 0, 8'h5A);
        go(3'd4, 8, 0, 0);
        for (int i = 0; i < 8; i++) idle(1, 1);
        check("rol8_q", 32'(q), 32'h5A);
        check("rol8_done", 32'(done), 32'h1);

        op(3'd5, 0, 0, 8'h01);
        go(3'd3, 15, 0, 0);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            idle(0, 0);
            if (busy) bcnt++;
        end
        check("amt15_busy_cycles", 32'(bcnt), 32'd8);
        check("amt15_q", 32'(q), 32'h01);

        op(3'd5, 0, 0, 8'hFF);
        go(3'd1, 6, 0, 0);
        for (int i = 0; i < 3; i++) idle(0, 0);
        check("abort_mid_q", 32'(q), 32'h1F);
        cyc(1, 0, 3'd0, 0, 0, 0, 0, '0);
        check("abort_q", 32'(q), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        idle(0, 0);
        check("abort_nodone", 32'(done), 32'h0);

        op(3'd5, 0, 0, 8'h80);
        go(3'd2, 2, 0, 1);
        idle(0, 1);
        idle(0, 1);
        check("b2b_done", 32'(done), 32'h1);
        check("b2b_q", 32'(q), 32'h03);
        go(3'd1, 1, 1, 0);
        check("b2b_busy", 32'(busy), 32'h1);
        idle(1, 0);
        check("b2b_done2", 32'(done), 32'h1);
        check("b2b_q2", 32'(q), 32'h81);

        op(3'd5, 0, 0, 8'h96);
        go(3'd1, 8, 0, 0);
        ser = '0;
        for (int i = 0; i < 8; i++) begin
            ser[i] = so_r;
            idle(0, 0);
        end
        ser_exp = 8'h96;
        check("serial_so_r", 32'(ser), 32'(ser_exp));
        check("serial_done", 32'(done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
